// File: rtl/lvds_rx_deframer.sv
// ============================================================================
// Module   : lvds_rx_deframer
// Purpose  : Locks to the I/Q sync pattern in a 2-bit/clock deserialized
//            stream, assembles 32-bit sample frames and pushes them to a FIFO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lvds_rx_deframer #(
  parameter int CNT_W = 8
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_b,
  input  logic             i_enable,
  input  logic [1:0]       i_ddr_data,
  input  logic             i_fifo_full,
  input  logic             i_clear_counters,
  output logic             o_fifo_push,
  output logic [31:0]      o_fifo_write_data,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_drop_count,
  output logic [CNT_W-1:0] o_sync_err_count
);

  localparam logic [1:0]       C_I_SYNC  = 2'b10;
  localparam logic [1:0]       C_Q_SYNC  = 2'b01;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_PHASE = 2'd1,
    ST_Q_PHASE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [29:0]      r_shift;
  logic [29:0]      w_shift_nxt;
  logic [29:0]      w_shift_in;
  logic             w_frame_done;
  logic             w_sync_err;
  logic             w_drop;
  logic             r_push;
  logic [31:0]      r_write_data;
  logic             r_locked;
  logic [CNT_W-1:0] r_drop_count;
  logic [CNT_W-1:0] r_sync_err_count;

  assign w_shift_in = {r_shift[27:0], i_ddr_data};
  assign w_drop     = w_frame_done & i_fifo_full;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_frame_done = 1'b0;
    w_sync_err   = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_ddr_data == C_I_SYNC) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = 4'd1;
            w_state_nxt = ST_I_PHASE;
          end
        end
        ST_I_PHASE: begin
          // cnt==0 only occurs on a back-to-back frame; its first pair is unchecked until here
          if (r_cnt == 4'd0 && i_ddr_data != C_I_SYNC) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_state_nxt = ST_Q_PHASE;
            end
          end
        end
        ST_Q_PHASE: begin
          if (r_cnt == 4'd8 && i_ddr_data != C_Q_SYNC) begin
            w_sync_err  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
          end else if (r_cnt == 4'd15) begin
            w_frame_done = 1'b1;
            w_shift_nxt  = w_shift_in;
            w_cnt_nxt    = 4'd0;
            w_state_nxt  = ST_I_PHASE;
          end else begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_cnt        <= 4'd0;
      r_shift      <= 30'd0;
      r_push       <= 1'b0;
      r_write_data <= 32'd0;
      r_locked     <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_push   <= w_frame_done & ~i_fifo_full;
      r_locked <= (w_state_nxt != ST_IDLE);
      if (w_frame_done) begin
        r_write_data <= {r_shift, i_ddr_data};
      end
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_drop_count     <= '0;
      r_sync_err_count <= '0;
    end else if (i_clear_counters) begin
      r_drop_count     <= '0;
      r_sync_err_count <= '0;
    end else begin
      if (w_drop && r_drop_count != C_CNT_MAX) begin
        r_drop_count <= r_drop_count + C_CNT_ONE;
      end
      if (w_sync_err && r_sync_err_count != C_CNT_MAX) begin
        r_sync_err_count <= r_sync_err_count + C_CNT_ONE;
      end
    end
  end

  assign o_fifo_push       = r_push;
  assign o_fifo_write_data = r_write_data;
  assign o_locked          = r_locked;
  assign o_drop_count      = r_drop_count;
  assign o_sync_err_count  = r_sync_err_count;

endmodule

`default_nettype wire

// File: tb/tb_lvds_rx_deframer.sv
// ============================================================================
// Module   : tb_lvds_rx_deframer
// Purpose  : Self-checking bench for lvds_rx_deframer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lvds_rx_deframer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             en;
  logic [1:0]       d;
  logic             full;
  logic             clr;
  logic             o_fifo_push;
  logic [31:0]      o_fifo_write_data;
  logic             o_locked;
  logic [CNT_W-1:0] o_drop_count;
  logic [CNT_W-1:0] o_sync_err_count;

  lvds_rx_deframer #(.CNT_W(CNT_W)) dut (
    .i_sys_clk         (clk),
    .i_rst_b           (rst_b),
    .i_enable          (en),
    .i_ddr_data        (d),
    .i_fifo_full       (full),
    .i_clear_counters  (clr),
    .o_fifo_push       (o_fifo_push),
    .o_fifo_write_data (o_fifo_write_data),
    .o_locked          (o_locked),
    .o_drop_count      (o_drop_count),
    .o_sync_err_count  (o_sync_err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int push_cnt = 0;
  int push_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_fifo_push) begin
      push_cnt = push_cnt + 1;
      push_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [31:0]      frame;
    int               npairs;
    logic             full;
    int               exp_push;
    logic [CNT_W-1:0] exp_drop;
    logic [CNT_W-1:0] exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [1:0] p);
    d = p;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pair_of(input logic [31:0] f, input int i);
    return f[31-2*i -: 2];
  endfunction

  task automatic feed(input logic [31:0] f, input int n);
    for (int i = 0; i < n; i++) tick(pair_of(f, i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    int          d1;
    int          d2;
    logic        locked_ok;
    logic [31:0] b2b[3];

    vecs[0] = '{32'hA5F35C21, 16, 1'b0, 1, 8'd0, 8'd0};
    vecs[1] = '{32'h80004000, 16, 1'b0, 1, 8'd0, 8'd0};
    vecs[2] = '{32'hA5F3DC21,  9, 1'b0, 0, 8'd0, 8'd1};
    vecs[3] = '{32'h9ABC5DEF, 16, 1'b0, 1, 8'd0, 8'd1};
    vecs[4] = '{32'h91234567, 16, 1'b1, 0, 8'd1, 8'd1};
    vecs[5] = '{32'hA0014002, 16, 1'b1, 0, 8'd2, 8'd1};
    b2b[0]  = 32'h80004000;
    b2b[1]  = 32'hBFFF7FFF;
    b2b[2]  = 32'h9ABC5DEF;

    rst_b = 1'b0; en = 1'b0; full = 1'b0; clr = 1'b0; d = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_push",   {31'd0, o_fifo_push}, 32'd0);
    check("reset_data",   o_fifo_write_data, 32'd0);
    check("reset_locked", {31'd0, o_locked}, 32'd0);
    check("reset_drop",   32'(o_drop_count), 32'd0);
    check("reset_err",    32'(o_sync_err_count), 32'd0);
    rst_b = 1'b1;
    tick(2'b00);

    // Single frame: push appears exactly one clock after the last pair
    en = 1'b1;
    p0 = push_cnt;
    feed(32'hA5F35C21, 15);
    check("t1_no_early_push", {31'd0, o_fifo_push}, 32'd0);
    tick(pair_of(32'hA5F35C21, 15));
    check("t1_push_pulse", {31'd0, o_fifo_push}, 32'd1);
    check("t1_data", o_fifo_write_data, 32'hA5F35C21);
    tick(2'b00);
    check("t1_push_single", {31'd0, o_fifo_push}, 32'd0);
    check("t1_push_count", 32'(push_cnt - p0), 32'd1);
    check("t1_locked_after", {31'd0, o_locked}, 32'd0);
    check("t1_drop", 32'(o_drop_count), 32'd0);
    check("t1_err", 32'(o_sync_err_count), 32'd0);

    // Three back-to-back frames
    push_cyc.delete();
    p0 = push_cnt;
    locked_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        tick(pair_of(b2b[k], i));
        if (!o_locked) locked_ok = 1'b0;
      end
    end
    check("t2_locked_held", {31'd0, locked_ok}, 32'd1);
    check("t2_last_data", o_fifo_write_data, 32'h9ABC5DEF);
    tick(2'b00);
    check("t2_push_count", 32'(push_cnt - p0), 32'd3);
    d1 = (push_cyc.size() >= 3) ? push_cyc[1] - push_cyc[0] : -1;
    d2 = (push_cyc.size() >= 3) ? push_cyc[2] - push_cyc[1] : -1;
    check("t2_spacing_01", 32'(d1), 32'd16);
    check("t2_spacing_12", 32'(d2), 32'd16);
    check("t2_unlock_gap", {31'd0, o_locked}, 32'd0);

    // Table: normal frames, sync error, recovery, FIFO-full drops
    for (int r = 0; r < 6; r++) begin
      p0   = push_cnt;
      full = vecs[r].full;
      feed(vecs[r].frame, vecs[r].npairs);
      full = 1'b0;
      tick(2'b00);
      check($sformatf("tbl%0d_push", r), 32'(push_cnt - p0), 32'(vecs[r].exp_push));
      if (vecs[r].exp_push != 0)
        check($sformatf("tbl%0d_data", r), o_fifo_write_data, vecs[r].frame);
      check($sformatf("tbl%0d_drop", r), 32'(o_drop_count), 32'(vecs[r].exp_drop));
      check($sformatf("tbl%0d_err", r), 32'(o_sync_err_count), 32'(vecs[r].exp_err));
      check($sformatf("tbl%0d_locked", r), {31'd0, o_locked}, 32'd0);
    end

    clr = 1'b1;
    tick(2'b00);
    clr = 1'b0;
    check("clear_drop", 32'(o_drop_count), 32'd0);
    check("clear_err", 32'(o_sync_err_count), 32'd0);

    // Clear coinciding with a sync error: clear wins
    feed(32'hA5F3DC21, 8);
    clr = 1'b1;
    tick(pair_of(32'hA5F3DC21, 8));
    clr = 1'b0;
    check("clr_prio_err", 32'(o_sync_err_count), 32'd0);
    check("clr_prio_locked", {31'd0, o_locked}, 32'd0);

    // Enable dropped at pair 9
    p0 = push_cnt;
    feed(32'hA5F35C21, 9);
    check("t5_locked_before", {31'd0, o_locked}, 32'd1);
    en = 1'b0;
    tick(pair_of(32'hA5F35C21, 9));
    check("t5_locked_after", {31'd0, o_locked}, 32'd0);
    en = 1'b1;
    tick(2'b00);
    check("t5_no_push", 32'(push_cnt - p0), 32'd0);
    check("t5_err", 32'(o_sync_err_count), 32'd0);
    check("t5_drop", 32'(o_drop_count), 32'd0);
    p0 = push_cnt;
    feed(32'hBFFF7FFF, 16);
    tick(2'b00);
    check("t5_recover_push", 32'(push_cnt - p0), 32'd1);
    check("t5_recover_data", o_fifo_write_data, 32'hBFFF7FFF);

    // Saturation of the sync-error counter
    for (int n = 0; n < 300; n++) feed(32'hA5F3DC21, 9);
    check("t6_err_sat", 32'(o_sync_err_count), 32'd255);
    check("t6_drop", 32'(o_drop_count), 32'd0);

    // Asynchronous reset mid-frame, between clock edges
    feed(32'hA5F35C21, 10);
    check("t6_locked_pre_rst", {31'd0, o_locked}, 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_push",   {31'd0, o_fifo_push}, 32'd0);
    check("arst_data",   o_fifo_write_data, 32'd0);
    check("arst_locked", {31'd0, o_locked}, 32'd0);
    check("arst_drop",   32'(o_drop_count), 32'd0);
    check("arst_err",    32'(o_sync_err_count), 32'd0);
    #3;
    rst_b = 1'b1;
    tick(2'b00);
    p0 = push_cnt;
    feed(32'h80004000, 16);
    tick(2'b00);
    check("arst_recover_push", 32'(push_cnt - p0), 32'd1);
    check("arst_recover_data", o_fifo_write_data, 32'h80004000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
